nfc_axil_regs: RTL
==================

# nfc_axil_regs

AXI4-Lite slave register bank that sits directly upstream of the NAND flash controller interface adapter. It gives the host processor write access to the command word, address and length. It launches commands to the adapter with one-cycle valid pulses. It exposes the adapter's status, ready/busy and command-fail outputs as readable registers, plus a command-issue counter.

## Interface
- No parameters; data width fixed at 32, address decode on iARAddr/iAWAddr[4:2].
- iSystemClock  in  1  clock
- iReset  in  1  synchronous, active-high reset
- iAWValid / oAWReady  in/out  1  write-address handshake
- iAWAddr  in  5  write byte address
- iWValid / oWReady  in/out  1  write-data handshake
- iWData  in  32  write data
- iWStrb  in  4  byte strobes
- oBValid / iBReady  out/in  1  write-response handshake
- oBResp  out  2  00 OKAY, 10 SLVERR
- iARValid / oARReady  in/out  1  read-address handshake
- iARAddr  in  5  read byte address
- oRValid / iRReady  out/in  1  read-data handshake
- oRData  out  32  read data
- oRResp  out  2  00 OKAY, 10 SLVERR
- oAxilValid  out  1  one-cycle pulse: field registers just updated
- oCommandValid  out  1  one-cycle pulse coincident with oAxilValid when COMMAND was written
- oCommand  out  32  COMMAND register
- oAddress  out  32  ADDRESS register
- oLength  out  16  LENGTH register
- iCommandFail  in  1  adapter command-rejected flag
- iNFCStatus  in  32  adapter status word
- iNandRBStatus  in  32  per-way ready/busy

## Operation
- Register map (byte offset):
  - 0x00 COMMAND: RW.
  - 0x04 ADDRESS: RW.
  - 0x08 LENGTH: RW. Bits [15:0] only; [31:16] read 0.
  - 0x0C NFC_STATUS: RO, returns iNFCStatus.
  - 0x10 RB_STATUS: RO, returns iNandRBStatus.
  - 0x14 FAIL: bit0 sticky; write 1 to bit0 clears it; other bits read 0.
  - 0x18 CMD_COUNT: RO; any write clears it to 0.
- Unmapped offsets 0x1C: writes are ignored with oBResp=10; reads return 0 with oRResp=10.
- RW registers honour iWStrb per byte.
- Writes to RO offsets 0x0C/0x10 are ignored with OKAY.
- Write FSM states:
  - W_IDLE: both readies high.
  - W_GOTADDR: oWReady only.
  - W_GOTDATA: oAWReady only.
  - W_COMMIT: one cycle, no readies.
  - W_RESP: hold oBValid until iBReady.
- AW and W may arrive in either order or the same cycle. When both are held, go to W_COMMIT.
- Only one write is outstanding at a time.
- W_COMMIT edge:
  - Update the target register.
  - Set oBValid and oBResp.
  - Pulse oAxilValid for writes to 0x00–0x08.
  - Pulse oCommandValid only for 0x00.
  - Go to W_RESP.
  - The pulse cycle already presents the new register values.
- Read FSM states:
  - R_IDLE: oARReady=1.
  - R_DATA: oRValid=1, oRData/oRResp held until iRReady, then back to R_IDLE.
- The read and write FSMs are independent and may run concurrently.
- FAIL[0] is set on any cycle where iCommandFail=1. If set and clear occur in the same cycle, set wins.
- CMD_COUNT increments on each oCommandValid pulse and wraps from 0xFFFFFFFF to 0. If a clear-write and a pulse coincide (same W_COMMIT), the result is 1.

## Timing
- Reset (iReset=1):
  - Both FSMs go idle; all registers and the counter become 0.
  - oBValid, oRValid, oAxilValid, oCommandValid, oBResp, oRResp and oRData are 0.
  - oAWReady, oWReady and oARReady are forced 0 while iReset=1, and become 1 the first cycle after.
- Reset mid-transaction: a pending response is dropped, no pulse is issued, and no register is partially written.
- Write latency: AW+W handshake at edge N → commit at edge N+1 → oBValid and the pulses are visible in cycle N+1. The pulses are exactly one cycle wide.
- Next write acceptance: readies return the cycle after the B handshake (B handshake at edge M → idle after edge M).
- Read latency: AR handshake at edge N → oRValid=1 and oRData registered in cycle N (after edge N).
- Read data is sampled at AR acceptance; a status change afterward does not alter held oRData.
- A read of FAIL or CMD_COUNT in the same cycle as an update returns the pre-update value.

## Test plan
- Reset, then read all offsets → 0x00–0x18 return 0 except 0x0C and 0x10, which follow their inputs; readies 1 after the reset cycle; oBValid=oRValid=0.
- Write ADDRESS=0x00012345, LENGTH=0xABCD1000, then COMMAND=0x00010003 with AW one cycle before W:
  - One oAxilValid pulse per write.
  - oCommandValid only on the COMMAND write, with oCommand=0x00010003, oAddress=0x00012345, oLength=0x1000.
  - Reading LENGTH returns 0x00001000.
- iWStrb=0010 write 0xFFFFFFFF to ADDRESS holding 0 → ADDRESS reads 0x0000FF00; OKAY response.
- Pulse iCommandFail → FAIL reads 1. Write 1 to FAIL coincident with a second iCommandFail pulse → FAIL still reads 1. Clean write of 1 → FAIL reads 0.
- Hold iBReady=0 for 5 cycles after a write → oBValid stays high; a new AW/W is not accepted until the B handshake. A concurrent read completes meanwhile.
- Write 0x1C and read 0x1C → oBResp=10, oRResp=10, oRData=0. Issue three COMMAND writes, then read CMD_COUNT → 3. Write CMD_COUNT → reads 0.

Source files
------------

// File: rtl/nfc_axil_regs_if.sv
// rtl/nfc_axil_regs_if.sv - AXI4-Lite channel bundle between host and the NFC register bank
interface nfc_axil_regs_if;
   logic        iAWValid;
   logic        oAWReady;
   logic [4:0]  iAWAddr;
   logic        iWValid;
   logic        oWReady;
   logic [31:0] iWData;
   logic [3:0]  iWStrb;
   logic        oBValid;
   logic        iBReady;
   logic [1:0]  oBResp;
   logic        iARValid;
   logic        oARReady;
   logic [4:0]  iARAddr;
   logic        oRValid;
   logic        iRReady;
   logic [31:0] oRData;
   logic [1:0]  oRResp;

   modport master (
      output iAWValid, iAWAddr, iWValid, iWData, iWStrb, iBReady, iARValid, iARAddr, iRReady,
      input  oAWReady, oWReady, oBValid, oBResp, oARReady, oRValid, oRData, oRResp
   );

   modport slave (
      input  iAWValid, iAWAddr, iWValid, iWData, iWStrb, iBReady, iARValid, iARAddr, iRReady,
      output oAWReady, oWReady, oBValid, oBResp, oARReady, oRValid, oRData, oRResp
   );
endinterface

// File: rtl/nfc_axil_regs.sv
// rtl/nfc_axil_regs.sv - AXI4-Lite register bank feeding the NAND flash controller adapter
module nfc_axil_regs (
   input  logic               iSystemClock,
   input  logic               iReset,
   nfc_axil_regs_if.slave     bus,
   output logic               oAxilValid,
   output logic               oCommandValid,
   output logic [31:0]        oCommand,
   output logic [31:0]        oAddress,
   output logic [15:0]        oLength,
   input  logic               iCommandFail,
   input  logic [31:0]        iNFCStatus,
   input  logic [31:0]        iNandRBStatus
);

   typedef enum logic [2:0] {W_IDLE, W_GOTADDR, W_GOTDATA, W_COMMIT, W_RESP} wstate_t;
   typedef enum logic {R_IDLE, R_DATA} rstate_t;

   wstate_t     wstate_q;
   rstate_t     rstate_q;
   logic [2:0]  waddr_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;

   logic [31:0] command_q, command_d;
   logic [31:0] address_q, address_d;
   logic [15:0] length_q, length_d;
   logic        fail_q, fail_d;
   logic [31:0] count_q, count_d;

   logic        bvalid_q;
   logic [1:0]  bresp_q;
   logic        axil_valid_q;
   logic        cmd_valid_q;
   logic        rvalid_q;
   logic [31:0] rdata_q;
   logic [1:0]  rresp_q;

   logic        aw_hs, w_hs, ar_hs, commit;
   logic [31:0] rd_mux;
   logic        unused_addr_bits;

   function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
      logic [31:0] r;
      r = old_v;
      for (int b = 0; b < 4; b++)
         if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
      return r;
   endfunction

   // Readies decode straight from state so they are low for the whole reset cycle.
   assign bus.oAWReady = ~iReset & ((wstate_q == W_IDLE) | (wstate_q == W_GOTDATA));
   assign bus.oWReady  = ~iReset & ((wstate_q == W_IDLE) | (wstate_q == W_GOTADDR));
   assign bus.oARReady = ~iReset & (rstate_q == R_IDLE);

   assign aw_hs  = bus.iAWValid & bus.oAWReady;
   assign w_hs   = bus.iWValid & bus.oWReady;
   assign ar_hs  = bus.iARValid & bus.oARReady;
   assign commit = (wstate_q == W_COMMIT);

   assign unused_addr_bits = ^{bus.iAWAddr[1:0], bus.iARAddr[1:0]};

   always_comb begin
      command_d = command_q;
      address_d = address_q;
      length_d  = length_q;
      fail_d    = fail_q;
      count_d   = count_q;
      if (commit) begin
         case (waddr_q)
            3'd0: begin
               command_d = apply_strb(command_q, wdata_q, wstrb_q);
               count_d   = count_q + 32'd1;
            end
            3'd1: address_d = apply_strb(address_q, wdata_q, wstrb_q);
            3'd2: begin
               if (wstrb_q[0]) length_d[7:0]  = wdata_q[7:0];
               if (wstrb_q[1]) length_d[15:8] = wdata_q[15:8];
            end
            3'd5: if (wstrb_q[0] && wdata_q[0]) fail_d = 1'b0;
            3'd6: count_d = 32'd0;
            default: ;
         endcase
      end
      // Placed last so a fail event beats a same-cycle clear.
      if (iCommandFail) fail_d = 1'b1;
   end

   always_comb begin
      rd_mux = 32'd0;
      case (bus.iARAddr[4:2])
         3'd0: rd_mux = command_q;
         3'd1: rd_mux = address_q;
         3'd2: rd_mux = {16'd0, length_q};
         3'd3: rd_mux = iNFCStatus;
         3'd4: rd_mux = iNandRBStatus;
         3'd5: rd_mux = {31'd0, fail_q};
         3'd6: rd_mux = count_q;
         default: rd_mux = 32'd0;
      endcase
   end

   always_ff @(posedge iSystemClock) begin
      if (iReset) begin
         wstate_q     <= W_IDLE;
         rstate_q     <= R_IDLE;
         waddr_q      <= 3'd0;
         wdata_q      <= 32'd0;
         wstrb_q      <= 4'd0;
         command_q    <= 32'd0;
         address_q    <= 32'd0;
         length_q     <= 16'd0;
         fail_q       <= 1'b0;
         count_q      <= 32'd0;
         bvalid_q     <= 1'b0;
         bresp_q      <= 2'b00;
         axil_valid_q <= 1'b0;
         cmd_valid_q  <= 1'b0;
         rvalid_q     <= 1'b0;
         rdata_q      <= 32'd0;
         rresp_q      <= 2'b00;
      end else begin
         command_q    <= command_d;
         address_q    <= address_d;
         length_q     <= length_d;
         fail_q       <= fail_d;
         count_q      <= count_d;
         axil_valid_q <= 1'b0;
         cmd_valid_q  <= 1'b0;

         if (aw_hs) waddr_q <= bus.iAWAddr[4:2];
         if (w_hs) begin
            wdata_q <= bus.iWData;
            wstrb_q <= bus.iWStrb;
         end

         case (wstate_q)
            W_IDLE: begin
               if (aw_hs && w_hs) wstate_q <= W_COMMIT;
               else if (aw_hs)    wstate_q <= W_GOTADDR;
               else if (w_hs)     wstate_q <= W_GOTDATA;
            end
            W_GOTADDR: if (w_hs)  wstate_q <= W_COMMIT;
            W_GOTDATA: if (aw_hs) wstate_q <= W_COMMIT;
            W_COMMIT: begin
               bvalid_q     <= 1'b1;
               bresp_q      <= (waddr_q == 3'd7) ? 2'b10 : 2'b00;
               axil_valid_q <= (waddr_q <= 3'd2);
               cmd_valid_q  <= (waddr_q == 3'd0);
               wstate_q     <= W_RESP;
            end
            W_RESP: begin
               if (bus.iBReady) begin
                  bvalid_q <= 1'b0;
                  wstate_q <= W_IDLE;
               end
            end
            default: wstate_q <= W_IDLE;
         endcase

         case (rstate_q)
            R_IDLE: begin
               if (ar_hs) begin
                  rvalid_q <= 1'b1;
                  rdata_q  <= rd_mux;
                  rresp_q  <= (bus.iARAddr[4:2] == 3'd7) ? 2'b10 : 2'b00;
                  rstate_q <= R_DATA;
               end
            end
            R_DATA: begin
               if (bus.iRReady) begin
                  rvalid_q <= 1'b0;
                  rstate_q <= R_IDLE;
               end
            end
            default: rstate_q <= R_IDLE;
         endcase
      end
   end

   assign bus.oBValid = bvalid_q;
   assign bus.oBResp  = bresp_q;
   assign bus.oRValid = rvalid_q;
   assign bus.oRData  = rdata_q;
   assign bus.oRResp  = rresp_q;

   assign oAxilValid    = axil_valid_q;
   assign oCommandValid = cmd_valid_q;
   assign oCommand      = command_q;
   assign oAddress      = address_q;
   assign oLength       = length_q;

endmodule
